sseg_scan_ctrl: RTL and testbench

//  Scan controller for the 4-digit, 7-segment display on the board.

---
 rtl/sseg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sseg_scan_ctrl
// Brief   : 4-digit 7-segment scanner, double-buffered digits, dead-time, LZB
// Revision: 1.0
// ============================================================================
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [1:0] cur_digit,
  output logic       pending,
  output logic       frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] C_DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    S_DRIVE = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [3:0][3:0] r_shadow;
  logic [3:0][3:0] r_active;
  logic [3:0]      r_sdp;
  logic [3:0]      r_adp;
  logic            r_pending;

  logic            w_boundary;
  logic            w_copy;
  logic [3:0][3:0] w_act;
  logic [3:0]      w_adp;
  logic [3:0]      w_zero_from;
  logic            w_lz;
  logic [6:0]      w_seg;

  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'h0: encode = 7'h40;  4'h1: encode = 7'h79;
      4'h2: encode = 7'h24;  4'h3: encode = 7'h30;
      4'h4: encode = 7'h19;  4'h5: encode = 7'h12;
      4'h6: encode = 7'h02;  4'h7: encode = 7'h78;
      4'h8: encode = 7'h00;  4'h9: encode = 7'h10;
      4'hA: encode = 7'h08;  4'hB: encode = 7'h03;
      4'hC: encode = 7'h46;  4'hD: encode = 7'h21;
      4'hE: encode = 7'h06;  default: encode = 7'h0E;
    endcase
  endfunction

  // The frame boundary is the edge that brings digit 0 back after digit 3;
  // the registered cur_digit still holds 3 at that edge.
  assign w_boundary = (r_state == S_DRIVE) && (r_idx == 2'd0) &&
                      (r_cnt == '0) && (cur_digit == 2'd3);
  assign w_copy     = w_boundary && (r_pending || commit);

  // Outputs on the boundary edge already show the freshly copied digits.
  assign w_act = w_copy ? r_shadow : r_active;
  assign w_adp = w_copy ? r_sdp    : r_adp;

  assign w_zero_from[3] = (w_act[3] == 4'd0);
  assign w_zero_from[2] = w_zero_from[3] && (w_act[2] == 4'd0);
  assign w_zero_from[1] = w_zero_from[2] && (w_act[1] == 4'd0);
  assign w_zero_from[0] = w_zero_from[1] && (w_act[0] == 4'd0);

  assign w_lz  = lz_en && (r_idx != 2'd0) && w_zero_from[r_idx];
  assign w_seg = w_lz ? 7'h7F : encode(w_act[r_idx]);

  assign pending = r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_DRIVE;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_sdp      <= '0;
      r_adp      <= '0;
      r_pending  <= 1'b0;
      an         <= 4'b1111;
      sseg       <= 8'hFF;
      cur_digit  <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      if (w_copy) begin
        r_active <= r_shadow;
        r_adp    <= r_sdp;
      end
      if (w_boundary)
        r_pending <= 1'b0;
      else if (commit)
        r_pending <= 1'b1;
      if (wr_en) begin
        r_shadow[wr_addr] <= wr_data;
        r_sdp[wr_addr]    <= wr_dp;
      end

      frame_tick <= w_boundary;
      cur_digit  <= r_idx;

      case (r_state)
        S_DRIVE: begin
          an   <= ~(4'b0001 << r_idx);
          sseg <= {~w_adp[r_idx], w_seg};
          if (r_cnt == C_DRIVE_LAST) begin
            r_cnt <= '0;
            if (BLANK_CYCLES == 0)
              r_idx <= r_idx + 2'd1;
            else
              r_state <= S_BLANK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          an   <= 4'b1111;
          sseg <= 8'hFF;
          if (r_cnt == C_BLANK_LAST) begin
            r_cnt   <= '0;
            r_idx   <= r_idx + 2'd1;
            r_state <= S_DRIVE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sseg_scan_ctrl
// Brief   : Self-checking bench for sseg_scan_ctrl against a frame-time model
// Revision: 1.0
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = R + B;
  localparam int FRAME = 4 * SLOT;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       commit = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] an, an2;
  logic [7:0] sseg, sseg2;
  logic [1:0] cur_digit, cur_digit2;
  logic       pending, pending2, frame_tick, frame_tick2;

  int total = 0;
  int bad   = 0;

  sseg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .commit(commit), .lz_en(lz_en), .an(an), .sseg(sseg),
    .cur_digit(cur_digit), .pending(pending), .frame_tick(frame_tick));

  sseg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .commit(commit), .lz_en(lz_en), .an(an2), .sseg(sseg2),
    .cur_digit(cur_digit2), .pending(pending2), .frame_tick(frame_tick2));

  always #5 clk = ~clk;

  wire [15:0] obs = {an, sseg, cur_digit, pending, frame_tick};

  // Model: t counts output cycles since reset release; everything else
  // follows from where t falls in the 20-cycle frame.
  int         m_t = -1;
  logic [3:0] m_sh [4];
  logic [3:0] m_ac [4];
  logic [3:0] m_sdp, m_adp;
  logic       m_pend;
  logic [15:0] exp_v;

  task automatic tick();
    int p, d, slot;
    bit bnd, z;
    logic [3:0] e_an;
    logic [7:0] e_sseg;
    @(posedge clk);
    if (rst) begin
      m_t = -1;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_ac[i] = 0; end
      m_sdp = 0; m_adp = 0; m_pend = 0;
      exp_v = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b0};
    end else begin
      m_t++;
      p   = m_t % FRAME;
      bnd = (m_t > 0) && (p == 0);
      if (bnd && (m_pend || commit)) begin
        for (int i = 0; i < 4; i++) m_ac[i] = m_sh[i];
        m_adp = m_sdp;
      end
      if (bnd) m_pend = 0;
      else if (commit) m_pend = 1;
      if (wr_en) begin m_sh[wr_addr] = wr_data; m_sdp[wr_addr] = wr_dp; end
      d    = p / SLOT;
      slot = p % SLOT;
      if (slot >= R) begin
        e_an = 4'hF; e_sseg = 8'hFF;
      end else begin
        z = 1;
        for (int j = d; j < 4; j++) if (m_ac[j] != 0) z = 0;
        e_an = ~(4'(1) << d);
        e_sseg = {~m_adp[d], (lz_en && d > 0 && z) ? 7'h7F : SEG[m_ac[d]]};
      end
      exp_v = {e_an, e_sseg, 2'(d), m_pend, bnd};
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] v, input logic dp);
    wr_en = 1; wr_addr = a; wr_data = v; wr_dp = dp;
    tick();
    wr_en = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs !== 16'hFFF0) begin bad++; $display("FAIL reset_const got=%h exp=%h", obs, 16'hFFF0); end
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v); end
    total++;
    if ({an2, sseg2, cur_digit2, pending2, frame_tick2} !== 16'hFFF0) begin
      bad++; $display("FAIL reset_nb got=%h exp=%h", {an2, sseg2, cur_digit2, pending2, frame_tick2}, 16'hFFF0);
    end
  endtask

  task automatic test_scan();
    int ticks = 0;
    lz_en = 0;
    for (int k = 0; k < 2 * FRAME + 5; k++) begin
      tick();
      if (frame_tick) ticks++;
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL scan t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
    total++;
    if (ticks !== 2) begin bad++; $display("FAIL scan_ticks got=%0d exp=2", ticks); end
  endtask

  task automatic test_commit();
    bit seen = 0;
    write(2'd3, 4'h1, 0); write(2'd2, 4'h2, 0); write(2'd1, 4'h3, 0); write(2'd0, 4'hF, 1);
    for (int k = 0; k < FRAME + 3; k++) begin
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL nocommit t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
    commit = 1; tick(); commit = 0;
    total++;
    if (pending !== 1'b1) begin bad++; $display("FAIL commit_pending got=%b exp=1", pending); end
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL commit t=%0d got=%h exp=%h", m_t, obs, exp_v); end
      if (frame_tick && !seen) begin
        seen = 1;
        total++;
        if ({an, sseg} !== {4'b1110, 8'h0E}) begin bad++; $display("FAIL commit_d0 got=%h exp=%h", {an, sseg}, {4'b1110, 8'h0E}); end
      end
      if (an === 4'b0111 && seen) begin
        total++;
        if (sseg !== 8'hF9) begin bad++; $display("FAIL commit_d3 got=%h exp=F9", sseg); end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL commit_tick got=0 exp=1"); end
  endtask

  task automatic test_lz();
    write(2'd3, 4'h0, 0); write(2'd2, 4'h0, 0); write(2'd1, 4'h0, 0); write(2'd0, 4'h7, 0);
    commit = 1; tick(); commit = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      lz_en = (k < 2 * FRAME);
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL lz t=%0d got=%h exp=%h", m_t, obs, exp_v); end
      if (lz_en && m_t % FRAME >= FRAME && an === 4'b1011) begin
        total++;
        if (sseg !== 8'hFF) begin bad++; $display("FAIL lz_d2 got=%h exp=FF", sseg); end
      end
    end
    lz_en = 0;
  endtask

  task automatic test_wr_on_boundary();
    commit = 1; tick(); commit = 0;
    for (int k = 0; k < FRAME && ((m_t + 1) % FRAME != 0); k++) tick();
    wr_en = 1; wr_addr = 0; wr_data = 4'h5; wr_dp = 0;
    tick();
    wr_en = 0;
    total++;
    if ({frame_tick, an, sseg} !== {1'b1, 4'b1110, 8'hF8}) begin
      bad++; $display("FAIL wr_bnd got=%h exp=%h", {frame_tick, an, sseg}, {1'b1, 4'b1110, 8'hF8});
    end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wr_bnd_hold t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
    commit = 1; tick(); commit = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL wr_bnd_apply t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 2'($urandom_range(3));
      wr_data = 4'($urandom_range(15));
      wr_dp   = 1'($urandom_range(1));
      commit  = ($urandom_range(15) == 0);
      if ($urandom_range(63) == 0) lz_en = ~lz_en;
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
    wr_en = 0; commit = 0; lz_en = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    write(2'd2, 4'h9, 1);
    k = 0;
    while (!(exp_v[0] === 1'b1) && k < 2 * FRAME) begin tick(); k++; end
    commit = 1; tick(); commit = 0;
    k = 0;
    while (!(an === 4'b1011 && m_t % SLOT == 1) && k < 2 * FRAME) begin tick(); k++; end
    total++;
    if (an !== 4'b1011 || pending !== 1'b1) begin bad++; $display("FAIL mid_setup got=%b/%b exp=1011/1", an, pending); end
    rst = 1; tick(); rst = 0;
    total++;
    if (obs !== 16'hFFF0) begin bad++; $display("FAIL mid_reset got=%h exp=%h", obs, 16'hFFF0); end
    tick();
    total++;
    if ({an, sseg, cur_digit} !== {4'b1110, 8'hC0, 2'd0}) begin
      bad++; $display("FAIL mid_restart got=%h exp=%h", {an, sseg, cur_digit}, {4'b1110, 8'hC0, 2'd0});
    end
    commit = 1; tick(); commit = 0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      tick();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL mid_after t=%0d got=%h exp=%h", m_t, obs, exp_v); end
    end
  endtask

  task automatic test_no_blank();
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      logic [13:0] want;
      tick();
      want = {~(4'(1) << ((k / R) % 4)), 8'hC0, 2'((k / R) % 4)};
      total++;
      if ({an2, sseg2, cur_digit2} !== want) begin
        bad++; $display("FAIL noblank k=%0d got=%h exp=%h", k, {an2, sseg2, cur_digit2}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_commit();
    test_lz();
    test_wr_on_boundary();
    test_random();
    test_reset_mid();
    test_no_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
